ss_scan_decoder: RTL

Receive-side counterpart of the seven-segment display driver: samples the multiplexed, active-low anode and cathode buses that the wall clock drives to the display and reconstructs the four BCD time digits. It sits in loopback, on the same board as the clock. It provides self-check and hardware-in-the-loop verification of the display path. It publishes only coherent frames, meaning all four digits captured since the previous publish, and flags illegal patterns and stalled scanning.

---
 rtl/ss_decode_pkg.sv | 61 ++++++
 rtl/seg_to_bcd.sv | 42 ++++
 rtl/ss_scan_decoder.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/ss_decode_pkg.sv
// ss_decode_pkg
//   Shared definitions for the seven-segment scan decoder:
//   - active-low gfedcba segment patterns for digits 0-9 and blank
//   - digit slot indices (anode bit positions)
//   - scan FSM state encoding
//   - small helpers that classify the anode bus
package ss_decode_pkg;

   // Active-low gfedcba cathode patterns (bit0 = a ... bit6 = g).
   localparam logic [6:0] SEG_0     = 7'h40;
   localparam logic [6:0] SEG_1     = 7'h79;
   localparam logic [6:0] SEG_2     = 7'h24;
   localparam logic [6:0] SEG_3     = 7'h30;
   localparam logic [6:0] SEG_4     = 7'h19;
   localparam logic [6:0] SEG_5     = 7'h12;
   localparam logic [6:0] SEG_6     = 7'h02;
   localparam logic [6:0] SEG_7     = 7'h78;
   localparam logic [6:0] SEG_8     = 7'h00;
   localparam logic [6:0] SEG_9     = 7'h10;
   localparam logic [6:0] SEG_BLANK = 7'h7F;

   // Digit slots, equal to the anode bit that selects them.
   localparam logic [1:0] MINS1  = 2'd0;
   localparam logic [1:0] MINS2  = 2'd1;
   localparam logic [1:0] HOURS1 = 2'd2;
   localparam logic [1:0] HOURS2 = 2'd3;

   typedef enum logic [1:0] {
      WAIT,
      SETTLE,
      CAPTURE,
      HELD
   } state_t;

   // One synchronised observation of the display bus.
   typedef struct packed {
      logic [3:0] anode;
      logic [6:0] seg;
   } sample_t;

   // A sample addresses a digit when exactly one of the four used anodes is
   // driven low and the unused anodes are idle high.
   function automatic logic is_addressed(input logic [7:0] anodes);
      logic [3:0] en;
      en = ~anodes[3:0];
      return (anodes[7:4] == 4'hF) && (en != 4'b0000) &&
             ((en & (en - 4'b0001)) == 4'b0000);
   endfunction

   // Slot index of the single low anode; only meaningful when addressed.
   function automatic logic [1:0] anode_index(input logic [3:0] anodes);
      case (anodes)
         4'b1110: return MINS1;
         4'b1101: return MINS2;
         4'b1011: return HOURS1;
         4'b0111: return HOURS2;
         default: return MINS1;
      endcase
   endfunction

endpackage

// File: rtl/seg_to_bcd.sv
// seg_to_bcd
//   Combinational lookup from an active-low gfedcba segment pattern to BCD.
//   Ports:
//     seg    in  7  cathode pattern, active-low, bit0 = a ... bit6 = g
//     valid  out 1  pattern is one of the ten digit glyphs
//     blank  out 1  pattern is all segments off (PWM dimming / dark)
//     digit  out 4  decoded BCD value, 0 when not valid
module seg_to_bcd
   import ss_decode_pkg::*;
(
   input  logic [6:0] seg,
   output logic       valid,
   output logic       blank,
   output logic [3:0] digit
);

   // NOTE: every output gets a default before the case so no path can leave
   // one unassigned and infer a latch.
   always_comb begin
      valid = 1'b1;
      blank = 1'b0;
      digit = 4'd0;
      case (seg)
         SEG_0:     digit = 4'd0;
         SEG_1:     digit = 4'd1;
         SEG_2:     digit = 4'd2;
         SEG_3:     digit = 4'd3;
         SEG_4:     digit = 4'd4;
         SEG_5:     digit = 4'd5;
         SEG_6:     digit = 4'd6;
         SEG_7:     digit = 4'd7;
         SEG_8:     digit = 4'd8;
         SEG_9:     digit = 4'd9;
         SEG_BLANK: begin
            valid = 1'b0;
            blank = 1'b1;
         end
         default:   valid = 1'b0;
      endcase
   end

endmodule

// File: rtl/ss_scan_decoder.sv
// ss_scan_decoder
//   Loopback receiver for the multiplexed seven-segment display bus. It
//   synchronises the anode and cathode buses, waits for each addressed digit
//   to hold steady for SETTLE_CYCLES samples, decodes it into a shadow
//   register and publishes all four digits together once every slot has been
//   captured since the previous publish.
//   Optional feature: define SS_DECODE_RANGE_CHECK_EN to publish only frames
//   that form a legal 24-hour time (mins2 <= 5, hours <= 23); rejected frames
//   set bad_pattern instead.
//   Ports:
//     CLK100MHZ       in  1  system clock
//     Reset           in  1  asynchronous, active-high reset
//     SegmentDrivers  in  8  anode enables, active-low (bit0 mins1 .. bit3 hours2)
//     SevenSegment    in  8  cathodes, active-low (bit0 a .. bit6 g, bit7 DP ignored)
//     hours2..mins1   out 4  last published BCD digits
//     frame_valid     out 1  one-cycle pulse when the digit outputs update
//     bad_pattern     out 1  sticky undecodable-pattern / rejected-frame flag
//     stale           out 1  no frame published for FRAME_TIMEOUT cycles
module ss_scan_decoder
   import ss_decode_pkg::*;
#(
   parameter int unsigned SETTLE_CYCLES = 4,
   parameter int unsigned FRAME_TIMEOUT = 2000000
) (
   input  logic       CLK100MHZ,
   input  logic       Reset,
   input  logic [7:0] SegmentDrivers,
   input  logic [7:0] SevenSegment,
   output logic [3:0] hours2,
   output logic [3:0] hours1,
   output logic [3:0] mins2,
   output logic [3:0] mins1,
   output logic       frame_valid,
   output logic       bad_pattern,
   output logic       stale
);

   localparam int unsigned CNT_W = $clog2(SETTLE_CYCLES + 1);
   localparam int unsigned TO_W  = $clog2(FRAME_TIMEOUT + 1);

   // ---------------------------------------------------------------------
   // Input synchronisers; idle state is all-ones (display dark).
   // ---------------------------------------------------------------------
   logic [7:0] an_meta, an_sync;
   logic [6:0] seg_meta, seg_sync;
   logic       dp_unused;

   assign dp_unused = SevenSegment[7];

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge value of its source.
   always_ff @(posedge CLK100MHZ or posedge Reset) begin
      if (Reset) begin
         an_meta  <= '1;
         an_sync  <= '1;
         seg_meta <= '1;
         seg_sync <= '1;
      end else begin
         an_meta  <= SegmentDrivers;
         an_sync  <= an_meta;
         seg_meta <= SevenSegment[6:0];
         seg_sync <= seg_meta;
      end
   end

   sample_t cur;
   logic    addressed;

   assign cur       = '{anode: an_sync[3:0], seg: seg_sync};
   assign addressed = is_addressed(an_sync);

   // ---------------------------------------------------------------------
   // Scan FSM: debounce one addressed digit at a time.
   // held_sample keeps the value being captured so a change during the
   // CAPTURE cycle is still seen as a change once HELD.
   // ---------------------------------------------------------------------
   state_t             state, state_next;
   logic [CNT_W-1:0]   settle_cnt, settle_cnt_next;
   sample_t            prev_sample, held_sample, held_next;

   always_ff @(posedge CLK100MHZ or posedge Reset) begin
      if (Reset) begin
         state       <= WAIT;
         settle_cnt  <= '0;
         prev_sample <= '1;
         held_sample <= '1;
      end else begin
         state       <= state_next;
         settle_cnt  <= settle_cnt_next;
         prev_sample <= cur;
         held_sample <= held_next;
      end
   end

   always_comb begin
      state_next      = state;
      settle_cnt_next = settle_cnt;
      held_next       = held_sample;
      case (state)
         WAIT: begin
            if (addressed) begin
               // A single-sample settle requirement is met on entry.
               if (SETTLE_CYCLES <= 1) begin
                  state_next = CAPTURE;
                  held_next  = cur;
               end else begin
                  state_next      = SETTLE;
                  settle_cnt_next = CNT_W'(1);
               end
            end
         end
         SETTLE: begin
            if (!addressed) begin
               state_next = WAIT;
            end else if (cur == prev_sample) begin
               if ((settle_cnt + CNT_W'(1)) == CNT_W'(SETTLE_CYCLES)) begin
                  state_next = CAPTURE;
                  held_next  = cur;
               end else begin
                  settle_cnt_next = settle_cnt + CNT_W'(1);
               end
            end else if (SETTLE_CYCLES <= 1) begin
               state_next = CAPTURE;
               held_next  = cur;
            end else begin
               settle_cnt_next = CNT_W'(1);
            end
         end
         CAPTURE: begin
            state_next = HELD;
         end
         HELD: begin
            if (cur != held_sample) begin
               if (!addressed) begin
                  state_next = WAIT;
               end else if (SETTLE_CYCLES <= 1) begin
                  state_next = CAPTURE;
                  held_next  = cur;
               end else begin
                  state_next      = SETTLE;
                  settle_cnt_next = CNT_W'(1);
               end
            end
         end
         default: state_next = WAIT;
      endcase
   end

   // ---------------------------------------------------------------------
   // Decode, shadow registers, frame assembly.
   // ---------------------------------------------------------------------
   logic       dec_valid, dec_blank;
   logic [3:0] dec_digit;
   logic [1:0] cap_idx;
   logic       capture;

   seg_to_bcd u_seg_to_bcd (
      .seg   (held_sample.seg),
      .valid (dec_valid),
      .blank (dec_blank),
      .digit (dec_digit)
   );

   assign capture = (state == CAPTURE);
   assign cap_idx = anode_index(held_sample.anode);

   logic [3:0]      shadow [4];
   logic [3:0]      seen;
   logic [TO_W-1:0] to_cnt;
   logic            frame_complete, publish, reject;

   assign frame_complete = (seen == 4'hF);

`ifdef SS_DECODE_RANGE_CHECK_EN
   logic range_ok;
   assign range_ok = (shadow[MINS2] <= 4'd5) && (shadow[HOURS2] <= 4'd2) &&
                     !((shadow[HOURS2] == 4'd2) && (shadow[HOURS1] > 4'd3));
   assign publish  = frame_complete & range_ok;
   assign reject   = frame_complete & ~range_ok;
`else
   assign publish  = frame_complete;
   assign reject   = 1'b0;
`endif

   // NOTE: the four-entry shadow array is reset along with the flags, so a
   // reset mid-frame can never leak a partial digit into a later publish.
   always_ff @(posedge CLK100MHZ or posedge Reset) begin
      if (Reset) begin
         for (int i = 0; i < 4; i++) shadow[i] <= 4'd0;
         seen        <= 4'h0;
         to_cnt      <= '0;
         hours2      <= 4'd0;
         hours1      <= 4'd0;
         mins2       <= 4'd0;
         mins1       <= 4'd0;
         frame_valid <= 1'b0;
         bad_pattern <= 1'b0;
      end else begin
         frame_valid <= publish;

         // Completed frames always retire the mask, published or rejected.
         if (frame_complete) seen <= 4'h0;

         if (capture && dec_valid) begin
            shadow[cap_idx] <= dec_digit;
            seen[cap_idx]   <= 1'b1;
         end

         if ((capture && !dec_valid && !dec_blank) || reject) bad_pattern <= 1'b1;

         if (publish) begin
            hours2 <= shadow[HOURS2];
            hours1 <= shadow[HOURS1];
            mins2  <= shadow[MINS2];
            mins1  <= shadow[MINS1];
            to_cnt <= '0;
         end else if (to_cnt != TO_W'(FRAME_TIMEOUT)) begin
            to_cnt <= to_cnt + TO_W'(1);
         end
      end
   end

   assign stale = (to_cnt == TO_W'(FRAME_TIMEOUT));

endmodule
